alu_seq: RTL and testbench

Issue sequencer for the combinational ALU. It accepts one data-processing or multiply command at a time through a valid/ready handshake and evaluates the ARM condition field against an internal NZCV register. It drives the ALU operands and op code for one cycle for data-processing, or iterates shift-add cycles through the ALU adder for MUL/MLA. It then registers the writeback and flag results.

---
 rtl/alu_seq_if.sv | 32 +++
 rtl/alu_seq.sv | 149 ++++++++++++++
 tb/tb_alu_seq.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Command and writeback bundle for the ALU issue sequencer.
// The master issues commands and receives writeback strobes; the sequencer is the slave.
interface alu_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_cond;
    logic [3:0]  cmd_op;
    logic        cmd_s;
    logic        cmd_mul;
    logic        cmd_acc;
    logic [3:0]  cmd_rd;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [31:0] cmd_c;
    logic        cmd_sh_cout;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        done;

    modport master (
        output cmd_valid, cmd_cond, cmd_op, cmd_s, cmd_mul, cmd_acc, cmd_rd,
               cmd_a, cmd_b, cmd_c, cmd_sh_cout,
        input  cmd_ready, wb_valid, wb_rd, wb_data, done
    );

    modport slave (
        input  cmd_valid, cmd_cond, cmd_op, cmd_s, cmd_mul, cmd_acc, cmd_rd,
               cmd_a, cmd_b, cmd_c, cmd_sh_cout,
        output cmd_ready, wb_valid, wb_rd, wb_data, done
    );
endinterface

// File: rtl/alu_seq.sv
// Issue sequencer for the combinational ALU: condition check against NZCV,
// single-cycle data-processing, and shift-add MUL/MLA through the ALU adder.
module alu_seq #(
    parameter bit MUL_EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_seq_if.slave    bus,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    output logic        alu_cin,
    output logic        alu_sh_cout,
    output logic        alu_vin,
    input  logic [31:0] alu_out,
    input  logic [3:0]  alu_nzcv,
    input  logic        flags_wr,
    input  logic [3:0]  flags_wdata,
    output logic [3:0]  flags
);
    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

    state_t      state_reg;
    logic [31:0] a_reg, b_reg, p_reg;
    logic [3:0]  op_reg, rd_reg, flags_reg;
    logic        s_reg, sh_reg;
    logic [4:0]  cnt_reg;
    logic        wb_valid_reg, done_reg;
    logic [3:0]  wb_rd_reg;
    logic [31:0] wb_data_reg;

    logic [31:0] p_next, m_next;
    logic        mul_last;

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'h0:    return z;
            4'h1:    return ~z;
            4'h2:    return c;
            4'h3:    return ~c;
            4'h4:    return n;
            4'h5:    return ~n;
            4'h6:    return v;
            4'h7:    return ~v;
            4'h8:    return c & ~z;
            4'h9:    return ~c | z;
            4'hA:    return n == v;
            4'hB:    return n != v;
            4'hC:    return ~z & (n == v);
            4'hD:    return z | (n != v);
            4'hE:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // In MUL, a_reg holds the shifting multiplicand and b_reg the shifting multiplier.
    assign p_next   = b_reg[0] ? alu_out : p_reg;
    assign m_next   = b_reg >> 1;
    assign mul_last = (MUL_EARLY_EXIT && (m_next == 32'd0)) || (cnt_reg == 5'd31);

    assign alu_a       = (state_reg == MUL) ? p_reg : a_reg;
    assign alu_b       = (state_reg == MUL) ? a_reg : b_reg;
    assign alu_op      = (state_reg == MUL) ? 4'h4 : op_reg;
    assign alu_cin     = flags_reg[1];
    assign alu_vin     = flags_reg[0];
    assign alu_sh_cout = sh_reg;
    assign flags       = flags_reg;

    assign bus.cmd_ready = (state_reg == IDLE);
    assign bus.wb_valid  = wb_valid_reg;
    assign bus.wb_rd     = wb_rd_reg;
    assign bus.wb_data   = wb_data_reg;
    assign bus.done      = done_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            a_reg        <= '0;
            b_reg        <= '0;
            p_reg        <= '0;
            op_reg       <= '0;
            rd_reg       <= '0;
            s_reg        <= 1'b0;
            sh_reg       <= 1'b0;
            cnt_reg      <= '0;
            flags_reg    <= '0;
            wb_valid_reg <= 1'b0;
            done_reg     <= 1'b0;
            wb_rd_reg    <= '0;
            wb_data_reg  <= '0;
        end else begin
            wb_valid_reg <= 1'b0;
            done_reg     <= 1'b0;
            // Later assignments below (EXEC/MUL flag results) override the external load.
            if (flags_wr)
                flags_reg <= flags_wdata;
            case (state_reg)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        op_reg  <= bus.cmd_op;
                        s_reg   <= bus.cmd_s;
                        rd_reg  <= bus.cmd_rd;
                        sh_reg  <= bus.cmd_sh_cout;
                        a_reg   <= bus.cmd_a;
                        b_reg   <= bus.cmd_b;
                        p_reg   <= bus.cmd_acc ? bus.cmd_c : 32'd0;
                        cnt_reg <= '0;
                        if (!cond_pass(bus.cmd_cond, flags_reg))
                            done_reg <= 1'b1;
                        else if (bus.cmd_mul)
                            state_reg <= MUL;
                        else
                            state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b1;
                    // Ops 10xx are compare/test forms: flags only, no writeback.
                    if (op_reg[3:2] != 2'b10) begin
                        wb_valid_reg <= 1'b1;
                        wb_rd_reg    <= rd_reg;
                        wb_data_reg  <= alu_out;
                    end
                    if (s_reg || (op_reg[3:2] == 2'b10))
                        flags_reg <= alu_nzcv;
                end
                MUL: begin
                    p_reg   <= p_next;
                    a_reg   <= a_reg << 1;
                    b_reg   <= m_next;
                    cnt_reg <= cnt_reg + 5'd1;
                    if (mul_last) begin
                        state_reg    <= IDLE;
                        done_reg     <= 1'b1;
                        wb_valid_reg <= 1'b1;
                        wb_rd_reg    <= rd_reg;
                        wb_data_reg  <= p_next;
                        if (s_reg)
                            flags_reg <= {p_next[31], p_next == 32'd0, flags_reg[1:0]};
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq with a behavioural ALU and a
// transaction-level reference model of condition, result, flags and latency.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_seq_if bus();
    alu_seq_if bus2();

    logic [31:0] alu_a, alu_b, alu_out, alu_a2, alu_b2, alu_out2;
    logic [3:0]  alu_op, alu_nzcv, alu_op2, alu_nzcv2;
    logic        alu_cin, alu_sh_cout, alu_vin, alu_cin2, alu_sh_cout2, alu_vin2;
    logic        flags_wr = 1'b0, flags_wr2 = 1'b0;
    logic [3:0]  flags_wdata = 4'h0, flags_wdata2 = 4'h0, flags, flags2;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] flags_m = 4'h0;

    // ARM data-processing semantics: returns {N,Z,C,V,result}.
    function automatic logic [35:0] arm_alu(input logic [3:0] op, input logic [31:0] a, b,
                                            input logic cin, shc, vin);
        logic [31:0] x, y, r;
        logic        ci, c, v;
        logic [32:0] sum;
        bit          arith;
        x = a; y = b; ci = 1'b0; arith = 1'b1; r = '0;
        case (op)
            4'd2, 4'd10: begin y = ~b; ci = 1'b1; end
            4'd3:        begin x = b; y = ~a; ci = 1'b1; end
            4'd4, 4'd11: ci = 1'b0;
            4'd5:        ci = cin;
            4'd6:        begin y = ~b; ci = cin; end
            4'd7:        begin x = b; y = ~a; ci = cin; end
            default:     arith = 1'b0;
        endcase
        sum = {1'b0, x} + {1'b0, y} + {32'd0, ci};
        if (arith) begin
            r = sum[31:0];
            c = sum[32];
            v = (x[31] == y[31]) && (r[31] != x[31]);
        end else begin
            c = shc;
            v = vin;
            case (op)
                4'd0, 4'd8: r = a & b;
                4'd1, 4'd9: r = a ^ b;
                4'd12:      r = a | b;
                4'd13:      r = b;
                4'd14:      r = a & ~b;
                default:    r = ~b;
            endcase
        end
        return {r[31], r == 32'd0, c, v, r};
    endfunction

    // Condition codes come in true/inverted pairs; 1110 is always, 1111 never.
    function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
        bit n, z, cy, v, r;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (cc[3:1])
            3'd0:    r = z;
            3'd1:    r = cy;
            3'd2:    r = n;
            3'd3:    r = v;
            3'd4:    r = cy && !z;
            3'd5:    r = (n == v);
            3'd6:    r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (cc == 4'hF) return 1'b0;
        if (cc == 4'hE) return 1'b1;
        return cc[0] ? !r : r;
    endfunction

    always_comb {alu_nzcv, alu_out}   = arm_alu(alu_op, alu_a, alu_b, alu_cin, alu_sh_cout, alu_vin);
    always_comb {alu_nzcv2, alu_out2} = arm_alu(alu_op2, alu_a2, alu_b2, alu_cin2, alu_sh_cout2, alu_vin2);

    alu_seq dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_sh_cout(alu_sh_cout), .alu_vin(alu_vin), .alu_out(alu_out), .alu_nzcv(alu_nzcv),
        .flags_wr(flags_wr), .flags_wdata(flags_wdata), .flags(flags)
    );

    alu_seq #(.MUL_EARLY_EXIT(1'b0)) dut_full (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_op(alu_op2), .alu_cin(alu_cin2),
        .alu_sh_cout(alu_sh_cout2), .alu_vin(alu_vin2), .alu_out(alu_out2), .alu_nzcv(alu_nzcv2),
        .flags_wr(flags_wr2), .flags_wdata(flags_wdata2), .flags(flags2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", tag, got, exp);
        end
    endtask

    task automatic load_flags(input logic [3:0] v);
        @(negedge clk);
        flags_wr = 1'b1;
        flags_wdata = v;
        @(posedge clk);
        #1 flags_wr = 1'b0;
        flags_m = v;
    endtask

    task automatic issue(input logic [3:0] cond, op, input bit s, mul, acc,
                         input logic [3:0] rd, input logic [31:0] a, b, c, input bit shc,
                         input bit fw_acc, fw_exec, input logic [3:0] fw_val, input string tag);
        bit          pass, exp_wb;
        logic [35:0] r;
        logic [31:0] exp_data;
        int          exp_lat, lat, k;
        pass = cond_ok(cond, flags_m);
        if (fw_acc) flags_m = fw_val;
        exp_wb = 1'b0;
        exp_data = '0;
        if (!pass) begin
            exp_lat = 1;
            if (fw_exec) flags_m = fw_val;
        end else if (!mul) begin
            r = arm_alu(op, a, b, flags_m[1], shc, flags_m[0]);
            exp_lat = 2;
            exp_wb = (op[3:2] != 2'b10);
            exp_data = r[31:0];
            if (s || op[3:2] == 2'b10) flags_m = r[35:32];
            else if (fw_exec) flags_m = fw_val;
        end else begin
            k = 1;
            for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
            exp_lat = k + 1;
            exp_wb = 1'b1;
            exp_data = a * b + (acc ? c : 32'd0);
            if (fw_exec && !(k == 1 && s)) flags_m = fw_val;
            if (s) flags_m = {exp_data[31], exp_data == 32'd0, flags_m[1:0]};
        end

        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_cond = cond; bus.cmd_op = op; bus.cmd_s = s;
        bus.cmd_mul = mul; bus.cmd_acc = acc; bus.cmd_rd = rd; bus.cmd_a = a;
        bus.cmd_b = b; bus.cmd_c = c; bus.cmd_sh_cout = shc;
        flags_wr = fw_acc; flags_wdata = fw_val;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        flags_wr = fw_exec;
        lat = 1;
        @(negedge clk);
        check({tag, "/ready"}, bus.cmd_ready, !pass);
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            #1 flags_wr = 1'b0;
            lat++;
            @(negedge clk);
        end
        check({tag, "/lat"}, lat, exp_lat);
        check({tag, "/wb_valid"}, bus.wb_valid, exp_wb);
        if (exp_wb) begin
            check({tag, "/wb_data"}, bus.wb_data, exp_data);
            check({tag, "/wb_rd"}, bus.wb_rd, rd);
        end
        @(posedge clk);
        #1 flags_wr = 1'b0;
        @(negedge clk);
        check({tag, "/done_pulse"}, bus.done, 1'b0);
        check({tag, "/flags"}, flags, flags_m);
        $display("txn %s cond=%h op=%h mul=%0d a=%h b=%h lat=%0d wb=%0d data=%h flags=%h",
                 tag, cond, op, mul, a, b, lat, bus.wb_valid, exp_data, flags_m);
    endtask

    initial begin
        int lat, nd;
        bus.cmd_valid = 1'b0; bus.cmd_cond = 4'hE; bus.cmd_op = 4'h0; bus.cmd_s = 1'b0;
        bus.cmd_mul = 1'b0; bus.cmd_acc = 1'b0; bus.cmd_rd = 4'h0; bus.cmd_a = '0;
        bus.cmd_b = '0; bus.cmd_c = '0; bus.cmd_sh_cout = 1'b0;
        bus2.cmd_valid = 1'b0; bus2.cmd_cond = 4'hE; bus2.cmd_op = 4'h0; bus2.cmd_s = 1'b0;
        bus2.cmd_mul = 1'b1; bus2.cmd_acc = 1'b0; bus2.cmd_rd = 4'h9; bus2.cmd_a = 32'd7;
        bus2.cmd_b = 32'd3; bus2.cmd_c = '0; bus2.cmd_sh_cout = 1'b0;

        repeat (3) @(negedge clk);
        check("rst/wb_valid", bus.wb_valid, 1'b0);
        check("rst/done", bus.done, 1'b0);
        check("rst/flags", flags, 4'h0);
        check("rst/wb_data", bus.wb_data, 32'd0);
        check("rst/ready", bus.cmd_ready, 1'b1);
        rst_n = 1'b1;

        issue(4'hE, 4'd4, 1, 0, 0, 4'd3, 32'd5, 32'd7, 0, 0, 0, 0, 4'h0, "adds");
        issue(4'hE, 4'd10, 0, 0, 0, 4'd1, 32'd3, 32'd3, 0, 0, 0, 0, 4'h0, "cmp");
        issue(4'h0, 4'd4, 0, 0, 0, 4'd2, 32'd10, 32'd20, 0, 0, 0, 0, 4'h0, "addeq");
        issue(4'h1, 4'd4, 0, 0, 0, 4'd2, 32'd10, 32'd20, 0, 0, 0, 0, 4'h0, "addne");
        issue(4'hE, 4'd2, 1, 0, 0, 4'd4, 32'd0, 32'd1, 0, 0, 0, 0, 4'h0, "subs");
        load_flags(4'b0010);
        issue(4'hE, 4'd5, 0, 0, 0, 4'd5, 32'd1, 32'd1, 0, 0, 0, 0, 4'h0, "adc");
        issue(4'hE, 4'd0, 0, 1, 0, 4'd6, 32'd3, 32'd5, 0, 0, 0, 0, 4'h0, "mul");
        load_flags(4'b0011);
        issue(4'hE, 4'd0, 1, 1, 1, 4'd7, 32'hFFFF_FFFF, 32'd2, 32'd1, 0, 0, 0, 4'h0, "mlas");
        issue(4'hE, 4'd0, 0, 1, 0, 4'd8, 32'd9, 32'd0, 0, 0, 0, 0, 4'h0, "mul0");
        issue(4'hE, 4'd4, 1, 0, 0, 4'd1, 32'd1, 32'd1, 0, 0, 0, 1, 4'hF, "adds_fw");
        issue(4'h0, 4'd4, 0, 0, 0, 4'd1, 32'd1, 32'd1, 0, 0, 1, 0, 4'b0100, "addeq_fw");

        for (int i = 0; i < 200; i++) begin
            logic [3:0] cc, op, fv;
            bit mul;
            logic [31:0] b;
            if ($urandom_range(0, 9) < 2) load_flags(4'($urandom));
            cc = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom);
            op = 4'($urandom);
            mul = ($urandom_range(0, 3) == 0);
            b = (mul && $urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 1023)) : $urandom;
            fv = 4'($urandom);
            issue(cc, op, 1'($urandom), mul, 1'($urandom), 4'($urandom), $urandom, b, $urandom,
                  1'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, fv,
                  $sformatf("rnd%0d", i));
        end

        @(negedge clk);
        bus2.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus2.cmd_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bus2.done && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("mul_full/lat", lat, 33);
        check("mul_full/wb_data", bus2.wb_data, 32'd21);
        $display("txn mul_full a=7 b=3 lat=%0d data=%h", lat, bus2.wb_data);

        load_flags(4'b1010);
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_cond = 4'hE; bus.cmd_mul = 1'b1; bus.cmd_acc = 1'b0;
        bus.cmd_s = 1'b1; bus.cmd_a = 32'd1; bus.cmd_b = 32'h8000_0000; bus.cmd_rd = 4'd5;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst/wb_valid", bus.wb_valid, 1'b0);
        check("mid_rst/done", bus.done, 1'b0);
        check("mid_rst/flags", flags, 4'h0);
        check("mid_rst/wb_rd", bus.wb_rd, 4'h0);
        check("mid_rst/ready", bus.cmd_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        flags_m = 4'h0;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done || bus.wb_valid) nd++;
        end
        check("mid_rst/no_done", nd, 0);
        check("mid_rst/ready_after", bus.cmd_ready, 1'b1);
        $display("txn mid_rst strobes_after=%0d", nd);

        issue(4'hE, 4'd13, 1, 0, 0, 4'd2, 32'd0, 32'h8000_0000, 0, 1, 0, 0, 4'h0, "movs_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
